// File: rtl/board_index_fetch.sv
// Purpose : maps VGA (drawX, drawY) to a 2x-downscaled board ROM address, returns the palette index with syncs aligned; counts frames.
// Latency : fixed 3 cycles from drawX/drawY/vde/hsync_i/vsync_i to index_o/vde_o/hsync_o/vsync_o; one pixel accepted per cycle.
// Backpres: none; the pipeline never stalls and never inserts bubbles.
//
// Ports: clk/reset_n (async active-low); drawX/drawY/vde/hsync_i/vsync_i from the VGA timing
// controller; rom_addr/rom_rd_en/rom_data to the synchronous board ROM (data one cycle after the
// read); index_o/vde_o/hsync_o/vsync_o to the palette lookup; frame_cnt counts falling vsync edges.
// Optional macro BOARD_BORDER_EN: an 8-pixel frame around the visible area is forced to index 2
// (black) without a ROM read.
module board_index_fetch #(
   parameter int           SCR_W       = 640,
   parameter int           SCR_H       = 480,
   parameter int           IMG_W       = 320,
   parameter int           IMG_H       = 240,
   parameter int           SCALE_SHIFT = 1,
   parameter int           ADDR_W      = 17,
   parameter logic [3:0]   BG_INDEX    = 4'd0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [9:0]        drawX,
   input  logic [9:0]        drawY,
   input  logic              vde,
   input  logic              hsync_i,
   input  logic              vsync_i,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic [3:0]        rom_data,
   output logic [3:0]        index_o,
   output logic              vde_o,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic [15:0]       frame_cnt
);

   localparam logic [9:0] SCR_W_L = 10'(SCR_W);
   localparam logic [9:0] SCR_H_L = 10'(SCR_H);
   localparam logic [9:0] IMG_W_L = 10'(IMG_W);
   localparam logic [9:0] IMG_H_L = 10'(IMG_H);

   logic [9:0]        img_x;
   logic [9:0]        img_y;
   logic [31:0]       row_off;
   logic [ADDR_W-1:0] addr_calc;
   logic              in_range;
   logic              fetch;

   // stage 1/2 sideband; rom_rd_en doubles as the stage-1 valid bit
   logic s1_vde, s1_hs, s1_vs;
   logic s2_vld, s2_vde, s2_hs, s2_vs;
   logic [3:0] idx_nxt;

   // frame counter state
   logic        vs_q;
   logic        vs_arm;
   logic [15:0] frame_q;

   always_comb begin
      img_x = drawX >> SCALE_SHIFT;
      img_y = drawY >> SCALE_SHIFT;
      // 320 = 256 + 64, so the row offset is two shifts and an add
      row_off = (IMG_W == 320) ? ((32'(img_y) << 8) + (32'(img_y) << 6))
                               : (32'(img_y) * IMG_W);
      addr_calc = ADDR_W'(row_off + 32'(img_x));
      // image-bound terms keep reads inside the ROM for non-default parameter sets
      in_range = vde && (drawX < SCR_W_L) && (drawY < SCR_H_L) &&
                 (img_x < IMG_W_L) && (img_y < IMG_H_L);
   end

`ifdef BOARD_BORDER_EN
   localparam logic [9:0] BRD_W  = 10'd8;
   localparam logic [9:0] BRD_XH = 10'(SCR_W - 8);
   localparam logic [9:0] BRD_YH = 10'(SCR_H - 8);
   localparam logic [3:0] BRD_INDEX = 4'd2;

   logic border;
   logic s1_brd, s2_brd;

   always_comb begin
      border = in_range && ((drawX < BRD_W) || (drawX >= BRD_XH) ||
                            (drawY < BRD_W) || (drawY >= BRD_YH));
      fetch  = in_range && !border;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_brd <= 1'b0;
         s2_brd <= 1'b0;
      end else begin
         s1_brd <= border;
         s2_brd <= s1_brd;
      end
   end

   always_comb begin
      idx_nxt = BG_INDEX;
      if (s2_brd)
         idx_nxt = BRD_INDEX;
      else if (s2_vld)
         idx_nxt = rom_data;
   end
`else
   always_comb begin
      fetch   = in_range;
      // rom_data is meaningless unless a read was issued for this slot
      idx_nxt = s2_vld ? rom_data : BG_INDEX;
   end
`endif

   // stage 1: address and read enable; address holds when no read is issued
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr  <= '0;
         rom_rd_en <= 1'b0;
         s1_vde    <= 1'b0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
      end else begin
         rom_rd_en <= fetch;
         if (fetch)
            rom_addr <= addr_calc;
         s1_vde <= vde;
         s1_hs  <= hsync_i;
         s1_vs  <= vsync_i;
      end
   end

   // stage 2: ROM is reading; stage 3: capture rom_data alongside the delayed syncs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_vld  <= 1'b0;
         s2_vde  <= 1'b0;
         s2_hs   <= 1'b1;
         s2_vs   <= 1'b1;
         index_o <= BG_INDEX;
         vde_o   <= 1'b0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         s2_vld  <= rom_rd_en;
         s2_vde  <= s1_vde;
         s2_hs   <= s1_hs;
         s2_vs   <= s1_vs;
         index_o <= idx_nxt;
         vde_o   <= s2_vde;
         hsync_o <= s2_hs;
         vsync_o <= s2_vs;
      end
   end

   // Frame counter. vs_q idles high; vs_arm only sets once vsync_i has been seen high,
   // so a sync that is already low when reset releases is not taken as a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q    <= 1'b1;
         vs_arm  <= 1'b0;
         frame_q <= 16'd0;
      end else begin
         vs_q <= vsync_i;
         if (vsync_i)
            vs_arm <= 1'b1;
         if (vs_arm && vs_q && !vsync_i)
            frame_q <= frame_q + 16'd1;
      end
   end

   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_board_index_fetch.sv
module tb_board_index_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  drawX, drawY;
   logic        vde, hsync_i, vsync_i;
   logic [16:0] rom_addr;
   logic        rom_rd_en;
   logic [3:0]  rom_data = 4'hF;
   logic [3:0]  index_o;
   logic        vde_o, hsync_o, vsync_o;
   logic [15:0] frame_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   board_index_fetch dut (
      .clk(clk), .reset_n(reset_n),
      .drawX(drawX), .drawY(drawY), .vde(vde), .hsync_i(hsync_i), .vsync_i(vsync_i),
      .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
      .index_o(index_o), .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .frame_cnt(frame_cnt)
   );

   // board ROM contents: a simple hash of the address
   function automatic logic [3:0] romf(input logic [16:0] a);
      return a[3:0] + a[7:4] + 4'd1;
   endfunction

   // synchronous ROM; garbage when no read is issued
   always @(posedge clk) rom_data <= rom_rd_en ? romf(rom_addr) : 4'hF;

   function automatic logic is_brd(input logic [9:0] x, input logic [9:0] y, input logic v);
`ifdef BOARD_BORDER_EN
      return v && x < 640 && y < 480 && (x < 8 || x >= 632 || y < 8 || y >= 472);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v,
                        input logic hs, input logic vs);
      drawX = x; drawY = y; vde = v; hsync_i = hs; vsync_i = vs;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},  rom_addr,  0);
      chk({tag, "_rd"},    rom_rd_en, 0);
      chk({tag, "_idx"},   index_o,   0);
      chk({tag, "_vde"},   vde_o,     0);
      chk({tag, "_hs"},    hsync_o,   1);
      chk({tag, "_vs"},    vsync_o,   1);
      chk({tag, "_frame"}, frame_cnt, 0);
   endtask

   typedef struct {
      logic [9:0]  x, y;
      logic        v, hs, vs;
      logic [16:0] addr;
      logic        rd;
      logic [3:0]  idx;
   } vec_t;

   vec_t tbl[8];

   // streaming history
   logic       h_vde[804], h_hs[804], h_vs[804], h_rd[804];
   logic [3:0] h_idx[804];
   logic [16:0] h_addr[804];

   initial begin
      logic [16:0] held;
      logic [16:0] e_addr;
      logic        e_rd;
      logic [3:0]  e_idx;
      logic [3:0]  r_idx;
      int          rel_x;

      //         x    y    v  hs vs  addr   rd idx
      tbl[0] = '{10'd0,   10'd0,   1, 1, 1, 17'd0,     1, 4'h1};
      tbl[1] = '{10'd5,   10'd3,   1, 0, 1, 17'd322,   1, 4'h7};
      tbl[2] = '{10'd639, 10'd479, 1, 1, 0, 17'd76799, 1, 4'hF};
      tbl[3] = '{10'd8,   10'd200, 1, 1, 1, 17'd32004, 1, 4'h5};
      tbl[4] = '{10'd3,   10'd200, 1, 0, 0, 17'd32001, 1, 4'h2};
      tbl[5] = '{10'd700, 10'd10,  1, 1, 1, 17'd0,     0, 4'h0};
      tbl[6] = '{10'd100, 10'd500, 1, 1, 1, 17'd0,     0, 4'h0};
      tbl[7] = '{10'd100, 10'd100, 0, 0, 1, 17'd0,     0, 4'h0};

      // reset state
      reset_n = 1'b0;
      drive(0, 0, 0, 1, 1);
      @(negedge clk);
      chk_reset_vals("rst");
      reset_n = 1'b1;

      // single-pixel vectors
      held = 17'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].hs, tbl[i].vs);
         e_rd = tbl[i].rd; e_idx = tbl[i].idx; e_addr = tbl[i].addr;
         if (is_brd(tbl[i].x, tbl[i].y, tbl[i].v)) begin
            e_rd = 1'b0; e_idx = 4'd2;
         end
         if (!e_rd) e_addr = held;
         held = e_addr;
         @(negedge clk);
         chk($sformatf("vec%0d_addr", i), rom_addr, e_addr);
         chk($sformatf("vec%0d_rd", i), rom_rd_en, e_rd);
         drive(0, 0, 0, 1, 1);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_idx", i), index_o, e_idx);
         chk($sformatf("vec%0d_vde", i), vde_o, tbl[i].v);
         chk($sformatf("vec%0d_hs", i), hsync_o, tbl[i].hs);
         chk($sformatf("vec%0d_vs", i), vsync_o, tbl[i].vs);
      end

      // full line on row 10: vde drops at column 640, hsync low 656..751
      for (int j = 0; j < 804; j++) begin
         @(negedge clk);
         if (j >= 1) begin
            chk($sformatf("line_rd_%0d", j - 1), rom_rd_en, h_rd[j-1]);
            if (h_rd[j-1])
               chk($sformatf("line_addr_%0d", j - 1), rom_addr, h_addr[j-1]);
         end
         if (j >= 3) begin
            chk($sformatf("line_idx_%0d", j - 3), index_o, h_idx[j-3]);
            chk($sformatf("line_vde_%0d", j - 3), vde_o, h_vde[j-3]);
            chk($sformatf("line_hs_%0d", j - 3), hsync_o, h_hs[j-3]);
         end
         if (j < 800) begin
            logic [9:0] x;
            logic       v, hs;
            x  = 10'(j);
            v  = (j < 640);
            hs = !(j >= 656 && j < 752);
            drive(x, 10'd10, v, hs, 1'b1);
            h_vde[j] = v; h_hs[j] = hs; h_vs[j] = 1'b1;
            h_addr[j] = 17'(5 * 320 + (j >> 1));
            if (is_brd(x, 10'd10, v)) begin
               h_rd[j] = 1'b0; h_idx[j] = 4'd2;
            end else begin
               h_rd[j]  = v;
               h_idx[j] = v ? romf(h_addr[j]) : 4'd0;
            end
         end else begin
            drive(0, 0, 0, 1, 1);
            h_vde[j] = 0; h_hs[j] = 1; h_vs[j] = 1; h_rd[j] = 0; h_idx[j] = 0; h_addr[j] = 0;
         end
      end

      // reset asserted mid-line at drawX=100
      for (int x = 0; x <= 100; x++) begin
         @(negedge clk);
         drive(10'(x), 10'd20, 1, 1, 1);
      end
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("midrst");
      for (int x = 101; x < 104; x++) begin
         @(negedge clk);
         drive(10'(x), 10'd20, 1, 1, 1);
      end
      @(negedge clk);
      rel_x = 104;
      drive(10'(rel_x), 10'd20, 1, 1, 1);
      reset_n = 1'b1;
      #1;
      chk("rel0_idx", index_o, 0);
      chk("rel0_vde", vde_o, 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) begin
            chk($sformatf("rel%0d_idx", k), index_o, 0);
            chk($sformatf("rel%0d_vde", k), vde_o, 0);
         end else begin
            r_idx = romf(17'(10 * 320 + (rel_x >> 1)));
            chk("rel3_idx", index_o, r_idx);
            chk("rel3_vde", vde_o, 1);
         end
         drive(10'(rel_x + k), 10'd20, 1, 1, 1);
      end

      // frame counter: reset released while vsync_i is low
      @(negedge clk);
      drive(0, 0, 0, 1, 0);
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("frame_after_rel", frame_cnt, 0);
      repeat (3) begin
         vsync_i = 1'b1;
         repeat (2) @(negedge clk);
         vsync_i = 1'b0;
         repeat (2) @(negedge clk);
      end
      vsync_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("frame_three", frame_cnt, 3);

      // wrap from 0xFFFF
      force dut.frame_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_q;
      @(negedge clk);
      chk("frame_preload", frame_cnt, 16'hFFFF);
      vsync_i = 1'b0;
      repeat (2) @(negedge clk);
      vsync_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("frame_wrap", frame_cnt, 0);
      vsync_i = 1'b0;
      repeat (2) @(negedge clk);
      vsync_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("frame_after_wrap", frame_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
